// File: rtl/ram_bus_arbiter_if.sv
// Master-side bus plus RAM data port of ram_bus_arbiter; ARB_LOCK_EN adds the per-master mLock wires.
// The slave modport is the arbiter's view; the master modport is the requesters' and RAM's view.
interface ram_bus_arbiter_if #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
);
   logic [NUM_MASTERS-1:0]          mReq;
   logic [NUM_MASTERS-1:0]          mWe;
   logic [NUM_MASTERS*ADDR_W-1:0]   mAddr;
   logic [NUM_MASTERS*DATA_W-1:0]   mWData;
   logic [NUM_MASTERS*DATA_W/8-1:0] mMask;
`ifdef ARB_LOCK_EN
   logic [NUM_MASTERS-1:0]          mLock;
`endif
   logic [NUM_MASTERS-1:0]          mGnt;
   logic [NUM_MASTERS-1:0]          mRValid;
   logic [NUM_MASTERS-1:0]          mErr;
   logic [DATA_W-1:0]               mRData;
   logic [ADDR_W-1:0]               memAddr;
   logic [DATA_W-1:0]               memWriteData;
   logic                            memWr;
   logic [DATA_W/8-1:0]             wrMask;
   logic [DATA_W-1:0]               memReadData;

   modport slave (
      input  `ifdef ARB_LOCK_EN mLock, `endif mReq, mWe, mAddr, mWData, mMask, memReadData,
      output mGnt, mRValid, mErr, mRData, memAddr, memWriteData, memWr, wrMask
   );

   modport master (
      output `ifdef ARB_LOCK_EN mLock, `endif mReq, mWe, mAddr, mWData, mMask, memReadData,
      input  mGnt, mRValid, mErr, mRData, memAddr, memWriteData, memWr, wrMask
   );
endinterface

// File: rtl/ram_bus_arbiter.sv
// Round-robin N-master to 1 RAM data-port arbiter with range fault; ARB_LOCK_EN enables bus locking.
// Grant is combinational in the request cycle, read data/fault pulse one cycle later; masters hold until mGnt.
module ram_bus_arbiter #(
   parameter int                NUM_MASTERS = 2,
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter logic [ADDR_W-1:0] ADDR_LIMIT  = ADDR_W'(32'h0000_4000)
) (
   input  logic               sysClk,
   input  logic               sysRes,
   ram_bus_arbiter_if.slave   bus
);
   localparam int PTR_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int MASK_W = DATA_W / 8;

   typedef logic [PTR_W-1:0] ptr_t;

   ptr_t                   rr_ptr_q, rr_ptr_d;
   ptr_t                   pend_id_q, pend_id_d;
   logic                   pend_rd_q, pend_rd_d;
   logic [NUM_MASTERS-1:0] err_q, err_d;
   logic [DATA_W-1:0]      rdata_q, rdata_d;

   ptr_t                   gnt_id;
   logic                   gnt_vld;
   logic                   lock_hold;
   logic [NUM_MASTERS-1:0] gnt_oh;
   logic [ADDR_W-1:0]      sel_addr;
   logic [DATA_W-1:0]      sel_wdata;
   logic [MASK_W-1:0]      sel_mask;
   logic                   sel_we;
   logic                   in_range;

   function automatic ptr_t wrap_inc(input ptr_t p);
      if (p == PTR_W'(NUM_MASTERS - 1)) return '0;
      return p + 1'b1;
   endfunction

`ifdef ARB_LOCK_EN
   logic lock_q, lock_d;
   ptr_t owner_q, owner_d;
   assign lock_hold = lock_q && bus.mReq[owner_q] && bus.mLock[owner_q];
`else
   assign lock_hold = 1'b0;
`endif

   always_comb begin
      logic [PTR_W:0] cand;
      cand    = '0;
      gnt_vld = 1'b0;
      gnt_id  = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
         if (cand >= (PTR_W+1)'(NUM_MASTERS)) cand = cand - (PTR_W+1)'(NUM_MASTERS);
         if (!gnt_vld && bus.mReq[cand[PTR_W-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_id  = cand[PTR_W-1:0];
         end
      end
`ifdef ARB_LOCK_EN
      if (lock_hold) begin
         gnt_vld = 1'b1;
         gnt_id  = owner_q;
      end
`endif
      if (sysRes) gnt_vld = 1'b0;
   end

   // With no grant gnt_id is 0, so the RAM port idles on master 0's request.
   always_comb begin
      sel_addr  = bus.mAddr[int'(gnt_id)*ADDR_W +: ADDR_W];
      sel_wdata = bus.mWData[int'(gnt_id)*DATA_W +: DATA_W];
      sel_mask  = bus.mMask[int'(gnt_id)*MASK_W +: MASK_W];
      sel_we    = bus.mWe[gnt_id];
      in_range  = sel_addr < ADDR_LIMIT;
      gnt_oh    = gnt_vld ? (NUM_MASTERS'(1) << gnt_id) : '0;
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (gnt_vld && !lock_hold) rr_ptr_d = wrap_inc(gnt_id);

      pend_rd_d = gnt_vld && !sel_we && in_range;
      pend_id_d = gnt_vld ? gnt_id : pend_id_q;
      err_d     = (gnt_vld && !in_range) ? gnt_oh : '0;

      // A faulting read zeroes the held data, even if a response is being captured this cycle.
      rdata_d = rdata_q;
      if (pend_rd_q) rdata_d = bus.memReadData;
      if (gnt_vld && !sel_we && !in_range) rdata_d = '0;
   end

`ifdef ARB_LOCK_EN
   always_comb begin
      lock_d  = 1'b0;
      owner_d = owner_q;
      if (gnt_vld) begin
         lock_d  = bus.mLock[gnt_id];
         owner_d = gnt_id;
      end
   end

   always_ff @(posedge sysClk or posedge sysRes) begin
      if (sysRes) begin
         lock_q  <= 1'b0;
         owner_q <= '0;
      end else begin
         lock_q  <= lock_d;
         owner_q <= owner_d;
      end
   end
`endif

   always_ff @(posedge sysClk or posedge sysRes) begin
      if (sysRes) begin
         rr_ptr_q  <= '0;
         pend_id_q <= '0;
         pend_rd_q <= 1'b0;
         err_q     <= '0;
         rdata_q   <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         pend_id_q <= pend_id_d;
         pend_rd_q <= pend_rd_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   assign bus.mGnt         = gnt_oh;
   assign bus.mRValid      = pend_rd_q ? (NUM_MASTERS'(1) << pend_id_q) : '0;
   assign bus.mErr         = err_q;
   assign bus.mRData       = pend_rd_q ? bus.memReadData : rdata_q;
   assign bus.memAddr      = sel_addr;
   assign bus.memWriteData = sel_wdata;
   assign bus.wrMask       = sel_mask;
   assign bus.memWr        = gnt_vld && sel_we && in_range;
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter with a small synchronous RAM behind the data port.
module tb_ram_bus_arbiter;
   localparam int NM = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = DW / 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   ram_bus_arbiter_if #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) bus ();

   ram_bus_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
      .sysClk (clk),
      .sysRes (rst),
      .bus    (bus)
   );

   // Word RAM indexed by addr[5:2]; 0x4000 aliases word 0, so a leaked fault write would show up there.
   logic [DW-1:0] ram [0:15];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) ram[i] <= '0;
         ram[0] <= 32'h0BAD_F00D;
         ram[4] <= 32'hDEAD_BEEF;
         bus.memReadData <= '0;
      end else begin
         if (bus.memWr)
            for (int b = 0; b < MW; b++)
               if (bus.wrMask[b]) ram[bus.memAddr[5:2]][b*8 +: 8] <= bus.memWriteData[b*8 +: 8];
         bus.memReadData <= ram[bus.memAddr[5:2]];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   task automatic drive(input int i, input logic req, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [MW-1:0] m);
      bus.mReq[i]              = req;
      bus.mWe[i]               = we;
      bus.mAddr[i*AW +: AW]    = a;
      bus.mWData[i*DW +: DW]   = d;
      bus.mMask[i*MW +: MW]    = m;
   endtask

   task automatic idle_all();
      for (int i = 0; i < NM; i++) drive(i, 1'b0, 1'b0, '0, '0, '0);
`ifdef ARB_LOCK_EN
      bus.mLock = '0;
`endif
   endtask

   task automatic do_reset();
      tick();
      idle_all();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_all();
      #1 rst = 1'b1;
      drive(0, 1'b1, 1'b1, 32'h10, 32'h1111_1111, 4'hF);
      drive(1, 1'b1, 1'b1, 32'h20, 32'h2222_2222, 4'hF);
      samp();
      total++; if (bus.mGnt !== 2'b00) begin bad++; $display("FAIL rst_gnt: got %b want 00", bus.mGnt); end
      total++; if (bus.memWr !== 1'b0) begin bad++; $display("FAIL rst_memwr: got %b want 0", bus.memWr); end
      total++; if (bus.mRValid !== 2'b00) begin bad++; $display("FAIL rst_rvalid: got %b want 00", bus.mRValid); end
      total++; if (bus.mErr !== 2'b00) begin bad++; $display("FAIL rst_err: got %b want 00", bus.mErr); end
      total++; if (bus.mRData !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", bus.mRData); end
      tick();
      idle_all();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_single_read();
      tick();
      drive(0, 1'b1, 1'b0, 32'h10, '0, '0);
      samp();
      total++; if (bus.mGnt !== 2'b01) begin bad++; $display("FAIL rd_gnt: got %b want 01", bus.mGnt); end
      total++; if (bus.memWr !== 1'b0) begin bad++; $display("FAIL rd_memwr: got %b want 0", bus.memWr); end
      total++; if (bus.memAddr !== 32'h10) begin bad++; $display("FAIL rd_addr: got %h want 10", bus.memAddr); end
      tick();
      idle_all();
      samp();
      total++; if (bus.mRValid !== 2'b01) begin bad++; $display("FAIL rd_rvalid: got %b want 01", bus.mRValid); end
      total++; if (bus.mRData !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_rdata: got %h want deadbeef", bus.mRData); end
   endtask

   task automatic test_contention();
      logic [1:0] exp_g;
      logic [1:0] prev_g;
      do_reset();
      prev_g = 2'b00;
      drive(0, 1'b1, 1'b0, 32'h10, '0, '0);
      drive(1, 1'b1, 1'b0, 32'h00, '0, '0);
      for (int c = 0; c < 4; c++) begin
         samp();
         exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
         total++; if (bus.mGnt !== exp_g) begin bad++; $display("FAIL rr_gnt%0d: got %b want %b", c, bus.mGnt, exp_g); end
         total++; if (bus.mRValid !== prev_g) begin bad++; $display("FAIL rr_rvalid%0d: got %b want %b", c, bus.mRValid, prev_g); end
         if (prev_g == 2'b01) begin
            total++; if (bus.mRData !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rr_rdata%0d: got %h want deadbeef", c, bus.mRData); end
         end else if (prev_g == 2'b10) begin
            total++; if (bus.mRData !== 32'h0BAD_F00D) begin bad++; $display("FAIL rr_rdata%0d: got %h want 0badf00d", c, bus.mRData); end
         end
         prev_g = exp_g;
         tick();
      end
      idle_all();
      samp();
      total++; if (bus.mRValid !== 2'b10) begin bad++; $display("FAIL rr_last_rvalid: got %b want 10", bus.mRValid); end
      total++; if (bus.mRData !== 32'h0BAD_F00D) begin bad++; $display("FAIL rr_last_rdata: got %h want 0badf00d", bus.mRData); end
   endtask

   task automatic test_masked_write();
      tick();
      drive(1, 1'b1, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0011);
      samp();
      total++; if (bus.mGnt !== 2'b10) begin bad++; $display("FAIL wr_gnt: got %b want 10", bus.mGnt); end
      total++; if (bus.memWr !== 1'b1) begin bad++; $display("FAIL wr_memwr: got %b want 1", bus.memWr); end
      total++; if (bus.wrMask !== 4'b0011) begin bad++; $display("FAIL wr_mask: got %b want 0011", bus.wrMask); end
      total++; if (bus.memWriteData !== 32'hAABB_CCDD) begin bad++; $display("FAIL wr_data: got %h want aabbccdd", bus.memWriteData); end
      total++; if (bus.memAddr !== 32'h20) begin bad++; $display("FAIL wr_addr: got %h want 20", bus.memAddr); end
      tick();
      drive(1, 1'b1, 1'b0, 32'h20, '0, '0);
      samp();
      total++; if (bus.mRValid !== 2'b00) begin bad++; $display("FAIL wr_no_rvalid: got %b want 00", bus.mRValid); end
      total++; if (bus.mErr !== 2'b00) begin bad++; $display("FAIL wr_no_err: got %b want 00", bus.mErr); end
      total++; if (bus.mGnt !== 2'b10) begin bad++; $display("FAIL wr_rd_gnt: got %b want 10", bus.mGnt); end
      tick();
      idle_all();
      samp();
      total++; if (bus.mRValid !== 2'b10) begin bad++; $display("FAIL wr_rd_rvalid: got %b want 10", bus.mRValid); end
      total++; if (bus.mRData !== 32'h0000_CCDD) begin bad++; $display("FAIL wr_rd_rdata: got %h want 0000ccdd", bus.mRData); end
   endtask

   task automatic test_fault();
      tick();
      drive(0, 1'b1, 1'b1, 32'h4000, 32'h1234_5678, 4'hF);
      samp();
      total++; if (bus.mGnt !== 2'b01) begin bad++; $display("FAIL flt_gnt: got %b want 01", bus.mGnt); end
      total++; if (bus.memWr !== 1'b0) begin bad++; $display("FAIL flt_memwr: got %b want 0", bus.memWr); end
      tick();
      drive(0, 1'b1, 1'b0, 32'h0, '0, '0);
      samp();
      total++; if (bus.mErr !== 2'b01) begin bad++; $display("FAIL flt_err: got %b want 01", bus.mErr); end
      total++; if (bus.mRValid !== 2'b00) begin bad++; $display("FAIL flt_rvalid: got %b want 00", bus.mRValid); end
      total++; if (bus.mGnt !== 2'b01) begin bad++; $display("FAIL flt_rb_gnt: got %b want 01", bus.mGnt); end
      tick();
      drive(0, 1'b1, 1'b0, 32'h5000, '0, '0);
      samp();
      total++; if (bus.mErr !== 2'b00) begin bad++; $display("FAIL flt_err_pulse: got %b want 00", bus.mErr); end
      total++; if (bus.mRValid !== 2'b01) begin bad++; $display("FAIL flt_rb_rvalid: got %b want 01", bus.mRValid); end
      total++; if (bus.mRData !== 32'h0BAD_F00D) begin bad++; $display("FAIL flt_rb_rdata: got %h want 0badf00d", bus.mRData); end
      tick();
      idle_all();
      samp();
      total++; if (bus.mErr !== 2'b01) begin bad++; $display("FAIL fltrd_err: got %b want 01", bus.mErr); end
      total++; if (bus.mRValid !== 2'b00) begin bad++; $display("FAIL fltrd_rvalid: got %b want 00", bus.mRValid); end
      total++; if (bus.mRData !== 32'h0) begin bad++; $display("FAIL fltrd_rdata: got %h want 0", bus.mRData); end
      tick();
      samp();
      total++; if (bus.mErr !== 2'b00) begin bad++; $display("FAIL fltrd_err_pulse: got %b want 00", bus.mErr); end
   endtask

   task automatic test_back_to_back();
      tick();
      drive(0, 1'b1, 1'b0, 32'h10, '0, '0);
      samp();
      total++; if (bus.mGnt !== 2'b01) begin bad++; $display("FAIL b2b_gnt0: got %b want 01", bus.mGnt); end
      tick();
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      drive(1, 1'b1, 1'b0, 32'h20, '0, '0);
      samp();
      total++; if (bus.mGnt !== 2'b10) begin bad++; $display("FAIL b2b_gnt1: got %b want 10", bus.mGnt); end
      total++; if (bus.mRValid !== 2'b01) begin bad++; $display("FAIL b2b_rvalid0: got %b want 01", bus.mRValid); end
      total++; if (bus.mRData !== 32'hDEAD_BEEF) begin bad++; $display("FAIL b2b_rdata0: got %h want deadbeef", bus.mRData); end
      tick();
      idle_all();
      samp();
      total++; if (bus.mRValid !== 2'b10) begin bad++; $display("FAIL b2b_rvalid1: got %b want 10", bus.mRValid); end
      total++; if (bus.mRData !== 32'h0000_CCDD) begin bad++; $display("FAIL b2b_rdata1: got %h want 0000ccdd", bus.mRData); end
   endtask

   task automatic test_reset_mid_read();
      tick();
      drive(0, 1'b1, 1'b0, 32'h10, '0, '0);
      samp();
      total++; if (bus.mGnt !== 2'b01) begin bad++; $display("FAIL rmr_gnt: got %b want 01", bus.mGnt); end
      tick();
      idle_all();
      rst = 1'b1;
      samp();
      total++; if (bus.mRValid !== 2'b00) begin bad++; $display("FAIL rmr_rvalid_rst: got %b want 00", bus.mRValid); end
      total++; if (bus.mRData !== 32'h0) begin bad++; $display("FAIL rmr_rdata_rst: got %h want 0", bus.mRData); end
      tick();
      rst = 1'b0;
      samp();
      total++; if (bus.mRValid !== 2'b00) begin bad++; $display("FAIL rmr_rvalid_rel: got %b want 00", bus.mRValid); end
      tick();
      drive(0, 1'b1, 1'b0, 32'h10, '0, '0);
      drive(1, 1'b1, 1'b0, 32'h20, '0, '0);
      samp();
      total++; if (bus.mGnt !== 2'b01) begin bad++; $display("FAIL rmr_ptr: got %b want 01", bus.mGnt); end
      tick();
      idle_all();
      samp();
      total++; if (bus.mRValid !== 2'b01) begin bad++; $display("FAIL rmr_rvalid_after: got %b want 01", bus.mRValid); end
   endtask

`ifdef ARB_LOCK_EN
   task automatic test_lock();
      tick();
      drive(0, 1'b1, 1'b0, 32'h10, '0, '0);
      samp();
      tick();
      drive(0, 1'b1, 1'b0, 32'h10, '0, '0);
      drive(1, 1'b1, 1'b0, 32'h20, '0, '0);
      bus.mLock = 2'b10;
      for (int c = 0; c < 3; c++) begin
         samp();
         total++; if (bus.mGnt !== 2'b10) begin bad++; $display("FAIL lock_gnt%0d: got %b want 10", c, bus.mGnt); end
         tick();
      end
      drive(1, 1'b0, 1'b0, '0, '0, '0);
      bus.mLock = 2'b00;
      samp();
      total++; if (bus.mGnt !== 2'b01) begin bad++; $display("FAIL lock_release: got %b want 01", bus.mGnt); end
      tick();
      idle_all();
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_read();
      test_contention();
      test_masked_write();
      test_fault();
      test_back_to_back();
      test_reset_mid_read();
`ifdef ARB_LOCK_EN
      test_lock();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ram_bus_arbiter.md
Name: ram_bus_arbiter

Overview:
- Parametrised N-master to 1-slave arbiter between bus masters and the data port of the shared dual-port RAM.
- Masters: CPU data port, plus DMA, debug or a second core in later tops.
- Round-robin grant per cycle; routes each master's request to the RAM and returns the read response one cycle later.
- Rejects out-of-range addresses with an error pulse, without touching memory.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (1..8).
- ADDR_W, 32, address width (byte address).
- DATA_W, 32, data width; mask width is DATA_W/8.
- ADDR_LIMIT, 32'h0000_4000, first illegal byte address; accesses at or above it fault.

Ports:
- sysClk  in  1  system clock, rising edge.
- sysRes  in  1  asynchronous active-high reset.
- mReq  in  NUM_MASTERS  per-master request.
- mWe  in  NUM_MASTERS  per-master write enable (1 = write, 0 = read).
- mAddr  in  NUM_MASTERS*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W].
- mWData  in  NUM_MASTERS*DATA_W  packed write data.
- mMask  in  NUM_MASTERS*DATA_W/8  packed byte write masks.
- mGnt  out  NUM_MASTERS  one-hot grant, combinational, same cycle as accept.
- mRValid  out  NUM_MASTERS  one-hot read-data valid, registered.
- mErr  out  NUM_MASTERS  one-hot access-fault pulse, registered.
- mRData  out  DATA_W  read data, shared; qualified by mRValid.
- memAddr  out  ADDR_W  RAM data-port address.
- memWriteData  out  DATA_W  RAM write data.
- memWr  out  1  RAM write enable.
- wrMask  out  DATA_W/8  RAM byte mask.
- memReadData  in  DATA_W  RAM read data, valid the cycle after the address.

Behaviour:
- Reset (async, sysRes=1):
  - rrPtr=0, mRValid=0, mErr=0, mRData=0, pendId=0, pendRd=0.
  - mGnt=0 and memWr=0 while sysRes is high.
- Arbitration:
  - Each cycle, the granted master is the first requesting index at or after rrPtr, searching cyclically.
  - At most one grant per cycle.
- Pointer update: on the grant edge, rrPtr <= granted+1, wrapping at NUM_MASTERS to 0. With no request, rrPtr holds.
- Handshake:
  - A master holds mReq, mAddr, mWData, mMask and mWe stable until it sees mGnt high.
  - Grant cycle = transfer cycle. The master may drop or change its request on the next cycle.
  - mReq must not be gated on mGnt (no combinational loop).
- Slave drive:
  - memAddr, memWriteData and wrMask mux from the granted master.
  - With no grant, they carry master 0's values.
  - memWr = grant & mWe & inRange.
- Range check:
  - inRange = addr < ADDR_LIMIT.
  - Out-of-range access: memWr forced 0; next cycle mErr[id]=1 for one cycle.
  - Out-of-range read: mRValid stays 0 and mRData is set to 0.
- Read latency:
  - An in-range read granted in cycle T yields mRValid[id]=1 in T+1, with mRData = memReadData captured in T+1.
  - Implementation: pendRd/pendId registered at T; mRData is the registered copy of memReadData, presented combinationally in T+1.
- Writes produce no response pulse. They complete on the grant edge.
- Back-to-back: a new grant in T+1 while the T read response is returned is legal. Full throughput is 1 transfer per cycle.
- NUM_MASTERS=1: always grants master 0 when requesting; rrPtr stays 0.
- Reset mid-read: the pending response is dropped; no mRValid after reset release.

Optional Feature:
- Macro: ARB_LOCK_EN.
- When defined:
  - Adds input mLock [NUM_MASTERS].
  - A granted master asserting mLock owns the bus. While it keeps mReq and mLock high, subsequent grants go only to it and rrPtr is frozen.
  - Lock releases on the first cycle the owner's mLock or mReq is low. Arbitration then resumes from owner+1.
  - Used for atomic read-modify-write.
- When undefined: no mLock port; pure round-robin.

Test Plan:
- Single read: M0 reads 0x10 holding 0xDEADBEEF -> mGnt=01 in T; mRValid=01 and mRData=0xDEADBEEF in T+1.
- Contention: M0 and M1 request continuously from reset -> grants alternate 01,10,01,10; each master gets 50%.
- Masked write: M1 writes 0xAABBCCDD, mask 4'b0011, to 0x20; then reads 0x20 (old value 0) -> read returns 0x0000CCDD.
- Fault: M0 writes to ADDR_LIMIT (0x4000) -> memWr=0 and mErr=01 next cycle; RAM is unchanged on read-back.
- Reset mid-read: sysRes pulsed in the cycle after a read grant -> mRValid stays 0; rrPtr=0 after release.
- ARB_LOCK_EN: M1 locks for 3 cycles while M0 requests -> mGnt=10 for all 3 cycles, then 01.
